// File: rtl/i2s_tx.sv
// I2S transmitter slaved to the codec's sclk/lrclk; serialises one held stereo pair per frame onto dout.
// dout moves SYNC_STAGES+1..+2 Clk after an sclk fall; s_ready stays low while a pair waits in the hold register.
`timescale 1ns/1ps
module i2s_tx #(
    parameter int SAMPLE_W    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                Clk,
    input  logic                Reset_h,
    input  logic                sclk,
    input  logic                lrclk,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                dout,
    output logic                frame_start,
    output logic                underrun,
    output logic [7:0]          underrun_cnt
);
    localparam int CNT_W = $clog2(SAMPLE_W + 1);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic                   sclk_s;
    logic                   sclk_d;
    logic                   lr_s;
    logic                   lr_prev;
    logic                   fe;
    logic                   boundary;
    logic                   left_bnd;
    logic                   right_bnd;
    logic                   xfer;

    logic [SAMPLE_W-1:0]    hold_l;
    logic [SAMPLE_W-1:0]    hold_r;
    logic                   hold_full;
    logic [SAMPLE_W-1:0]    act_l;
    logic [SAMPLE_W-1:0]    act_r;
    logic [SAMPLE_W-1:0]    shreg;
    logic [CNT_W-1:0]       bitcnt;

    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            sclk_sync <= '0;
            lr_sync   <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(sclk);
            lr_sync   <= (lr_sync << 1) | SYNC_STAGES'(lrclk);
            sclk_d    <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign lr_s      = lr_sync[SYNC_STAGES-1];
    assign fe        = sclk_d & ~sclk_s;
    assign boundary  = fe & (lr_s != lr_prev);
    assign left_bnd  = boundary & ~lr_s;
    assign right_bnd = boundary & lr_s;

    assign s_ready = ~hold_full & ~Reset_h;
    assign xfer    = s_valid & s_ready;

    // A transfer can only land while hold is empty, and a left boundary only
    // clears hold when it is full, so the two never fight over hold_full.
    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            hold_l       <= '0;
            hold_r       <= '0;
            hold_full    <= 1'b0;
            act_l        <= '0;
            act_r        <= '0;
            shreg        <= '0;
            bitcnt       <= '0;
            dout         <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            lr_prev      <= 1'b1;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;

            if (fe)
                lr_prev <= lr_s;

            if (xfer) begin
                hold_l    <= s_left;
                hold_r    <= s_right;
                hold_full <= 1'b1;
            end

            if (left_bnd) begin
                frame_start <= 1'b1;
                dout        <= 1'b0;
                bitcnt      <= '0;
                if (hold_full) begin
                    act_l     <= hold_l;
                    act_r     <= hold_r;
                    shreg     <= hold_l;
                    hold_full <= 1'b0;
                end else begin
                    act_l    <= '0;
                    act_r    <= '0;
                    shreg    <= '0;
                    underrun <= 1'b1;
                    if (underrun_cnt != 8'hFF)
                        underrun_cnt <= underrun_cnt + 8'd1;
                end
            end else if (right_bnd) begin
                shreg  <= act_r;
                dout   <= 1'b0;
                bitcnt <= '0;
            end else if (fe) begin
                if (bitcnt < CNT_W'(SAMPLE_W)) begin
                    dout   <= shreg[SAMPLE_W-1];
                    shreg  <= shreg << 1;
                    bitcnt <= bitcnt + CNT_W'(1);
                end else begin
                    dout <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: drives codec-style sclk/lrclk and checks each slot's serial bits against a frame-level model.
`timescale 1ns/1ps
module tb_i2s_tx;
    localparam int SAMPLE_W = 16;
    localparam int SYNC     = 2;
    localparam int HALF     = 5;

    logic                Clk;
    logic                Reset_h;
    logic                sclk;
    logic                lrclk;
    logic                s_valid;
    logic                s_ready;
    logic [SAMPLE_W-1:0] s_left;
    logic [SAMPLE_W-1:0] s_right;
    logic                dout;
    logic                frame_start;
    logic                underrun;
    logic [7:0]          underrun_cnt;

    i2s_tx #(.SAMPLE_W(SAMPLE_W), .SYNC_STAGES(SYNC)) dut (
        .Clk          (Clk),
        .Reset_h      (Reset_h),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_left       (s_left),
        .s_right      (s_right),
        .dout         (dout),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    int vec;
    int errs;
    int fs_seen;
    int ur_seen;
    int m_fs;
    int m_ur;
    int m_cnt;
    int frame_no;
    logic [31:0]         pend[$];
    logic [SAMPLE_W-1:0] m_l;
    logic [SAMPLE_W-1:0] m_r;

    // Cycles spent high, so a stretched pulse shows up as an extra count.
    always @(posedge Clk) begin
        if (frame_start === 1'b1) fs_seen <= fs_seen + 1;
        if (underrun === 1'b1)    ur_seen <= ur_seen + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One Clk step, entered and left 5 ns after a rising edge.
    task automatic tick(input bit raise);
        bit hs;
        hs = s_valid && s_ready;
        @(posedge Clk);
        #1;
        if (hs) begin
            s_valid = 1'b0;
            pend.push_back({s_left, s_right});
        end
        if (raise) s_valid = 1'b1;
        #4;
    endtask

    // One sclk period; dout is sampled just before the rising edge, as a codec would.
    task automatic sclk_bit(input logic lr, input bit push_bnd, output logic d);
        sclk  = 1'b0;
        lrclk = lr;
        for (int c = 0; c < HALF; c++) tick(push_bnd && c == SYNC - 1);
        d    = dout;
        sclk = 1'b1;
        for (int c = 0; c < HALF; c++) tick(1'b0);
    endtask

    function automatic logic exp_bit(input logic [SAMPLE_W-1:0] w, input int k);
        if (k >= 1 && k <= SAMPLE_W) return w[SAMPLE_W-k];
        return 1'b0;
    endfunction

    task automatic run_slot(input logic lr, input int len, input bit push_bnd, input bit chk);
        logic [63:0]         got;
        logic [63:0]         exp;
        logic [SAMPLE_W-1:0] w;
        logic                d;
        if (!lr) begin
            m_fs++;
            if (pend.size() > 0) begin
                {m_l, m_r} = pend.pop_front();
            end else begin
                m_l = '0;
                m_r = '0;
                m_ur++;
                if (m_cnt < 255) m_cnt++;
            end
        end
        w   = lr ? m_r : m_l;
        got = '0;
        exp = '0;
        for (int k = 0; k < len; k++) begin
            sclk_bit(lr, push_bnd && k == 0, d);
            got = {got[62:0], d};
            exp = {exp[62:0], exp_bit(w, k)};
        end
        if (chk) check($sformatf("%s slot f%0d", lr ? "R" : "L", frame_no), got, exp);
    endtask

    task automatic check_counts();
        check("frame_start pulses", 64'(fs_seen), 64'(m_fs));
        check("underrun pulses", 64'(ur_seen), 64'(m_ur));
        check("underrun_cnt", 64'(underrun_cnt), 64'(m_cnt));
    endtask

    task automatic frame(input int llen, input int rlen, input bit chk);
        frame_no++;
        run_slot(1'b0, llen, 1'b0, chk);
        run_slot(1'b1, rlen, 1'b0, chk);
        if (chk) check_counts();
    endtask

    task automatic push(input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r, input string tag);
        s_left  = l;
        s_right = r;
        s_valid = 1'b1;
        for (int i = 0; i < 20 && s_valid; i++) tick(1'b0);
        check({tag, " accepted"}, 64'(s_valid), 64'(0));
        s_valid = 1'b0;
    endtask

    initial begin
        vec = 0; errs = 0; fs_seen = 0; ur_seen = 0;
        m_fs = 0; m_ur = 0; m_cnt = 0; frame_no = 0;
        m_l = '0; m_r = '0;
        Reset_h = 1'b1; sclk = 1'b1; lrclk = 1'b1; s_valid = 1'b0;
        s_left = '0; s_right = '0;
        @(posedge Clk); #5;
        for (int i = 0; i < 4; i++) tick(1'b0);

        check("rst dout", 64'(dout), 64'(0));
        check("rst frame_start", 64'(frame_start), 64'(0));
        check("rst underrun", 64'(underrun), 64'(0));
        check("rst underrun_cnt", 64'(underrun_cnt), 64'(0));
        check("rst s_ready", 64'(s_ready), 64'(0));
        Reset_h = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        check("post-rst s_ready", 64'(s_ready), 64'(1));

        // Starved first frame after reset.
        frame(32, 32, 1'b1);

        // Single pair, 32-bit slots.
        push(16'hA5C3, 16'h8001, "A5C3");
        check("s_ready while held", 64'(s_ready), 64'(0));
        frame(32, 32, 1'b1);
        check("s_ready after bnd", 64'(s_ready), 64'(1));

        // Second pair waits with s_valid high until the hold register frees.
        push(16'h0F0F, 16'hF0F0, "0F0F");
        s_left = 16'h1234; s_right = 16'h5678; s_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0);
        check("s_ready blocked", 64'(s_ready), 64'(0));
        frame(32, 32, 1'b1);
        check("second pair held", 64'(s_ready), 64'(0));
        frame(32, 32, 1'b1);

        // Pair offered in the boundary cycle itself: underrun now, plays next frame.
        s_left = 16'hCAFE; s_right = 16'hBEEF;
        frame_no++;
        run_slot(1'b0, 32, 1'b1, 1'b1);
        run_slot(1'b1, 32, 1'b0, 1'b1);
        check_counts();
        frame(32, 32, 1'b1);

        // Short right slot, then a normal frame.
        push(16'h9C3B, 16'hE71D, "short");
        frame(32, 10, 1'b1);
        push(16'h4411, 16'h2288, "after short");
        frame(32, 32, 1'b1);

        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(3) != 0) push(16'($urandom), 16'($urandom), "rnd");
            frame(int'($urandom_range(32, 10)), int'($urandom_range(32, 10)), 1'b1);
        end

        // Reset in the middle of a left word.
        push(16'h7E81, 16'h0FF0, "pre-rst");
        frame_no++;
        run_slot(1'b0, 8, 1'b0, 1'b0);
        Reset_h = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0);
        check("mid rst dout", 64'(dout), 64'(0));
        check("mid rst s_ready", 64'(s_ready), 64'(0));
        pend.delete();
        m_l = '0; m_r = '0; m_cnt = 0;
        Reset_h = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        check("mid rst cnt", 64'(underrun_cnt), 64'(0));
        frame(32, 32, 1'b1);
        push(16'h5AA5, 16'hC00C, "post-rst");
        frame(32, 32, 1'b1);

        // Long starvation: counter saturates.
        for (int f = 0; f < 300; f++) frame(2, 2, 1'b0);
        check_counts();
        check("sat 255", 64'(underrun_cnt), 64'(255));
        frame(2, 2, 1'b1);
        check("sat hold", 64'(underrun_cnt), 64'(255));

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter SAMPLE_W, default 16, sets the bits per channel sample.
REQ-002 Parameter SYNC_STAGES, default 2, sets the synchronizer depth on sclk and lrclk.
REQ-003 Port Clk, input, 1 bit: system clock (50 MHz); the block SHALL use one clock.
REQ-004 Port Reset_h, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port sclk, input, 1 bit: codec I2S bit clock; asynchronous to Clk; codec is I2S master.
REQ-006 Port lrclk, input, 1 bit: codec word select; 0 = left, 1 = right.
REQ-007 Port s_valid, input, 1 bit: upstream stereo sample pair valid.
REQ-008 Port s_ready, output, 1 bit: block can accept a sample pair.
REQ-009 Port s_left, input, SAMPLE_W bits: left sample, two's complement.
REQ-010 Port s_right, input, SAMPLE_W bits: right sample, two's complement.
REQ-011 Port dout, output, 1 bit: serial data to codec DIN.
REQ-012 Port frame_start, output, 1 bit: one-Clk pulse when a left word is loaded.
REQ-013 Port underrun, output, 1 bit: one-Clk pulse when a frame starts with no sample pair held.
REQ-014 Port underrun_cnt, output, 8 bits: count of underruns, saturating.

Function
REQ-015 sclk and lrclk SHALL pass through SYNC_STAGES flops each; all logic SHALL use the synchronized copies only.
REQ-016 A falling edge (fe) SHALL be the synced sclk going 1 then 0 on consecutive Clk cycles; the fe strobe lasts exactly one Clk.
REQ-017 Each fe SHALL capture the synced lrclk into lr_prev; a word boundary is fe with synced lrclk != lr_prev.
REQ-018 Hold register: a transfer occurs when s_valid & s_ready; {s_left, s_right} latch into hold and hold_full sets.
REQ-019 s_ready SHALL equal ~hold_full & ~Reset_h; combinational, with no dependence on s_valid.
REQ-020 Left boundary (lrclk 1->0), hold_full=1: copy hold into act_L/act_R, clear hold_full, load shreg from the hold-register left sample, pulse frame_start.
REQ-021 Left boundary, hold_full=0: load act_L/act_R and shreg with 0, pulse frame_start and underrun, increment underrun_cnt (saturates at 255).
REQ-022 Transfer and left boundary in the same Clk with hold empty: the boundary SHALL take the REQ-021 underrun path; the accepted pair SHALL remain in hold for the next frame.
REQ-023 Right boundary (lrclk 0->1): shreg SHALL load act_R; no pulses.
REQ-024 At a boundary fe, dout SHALL drive 0 and bitcnt SHALL reset to 0 (I2S one-bit delay).
REQ-025 On each following fe, while bitcnt < SAMPLE_W: dout <= shreg MSB, shreg shifts left by 1, bitcnt increments.
REQ-026 On fe with bitcnt = SAMPLE_W: dout SHALL drive 0 (padding for slots wider than SAMPLE_W).
REQ-027 Short slot: a boundary arriving before SAMPLE_W bits are sent SHALL abandon the remaining bits and take the new boundary action.
REQ-028 dout SHALL be registered; latency from the sclk pin falling edge to dout change is SYNC_STAGES+1 to SYNC_STAGES+2 Clk.
REQ-029 The block SHALL operate correctly for sclk frequency <= Clk/8.

Reset
REQ-030 Reset_h high SHALL asynchronously clear synchronizers, shreg, act_L, act_R, hold, hold_full, bitcnt, dout, frame_start, underrun and underrun_cnt to 0.
REQ-031 Reset SHALL set lr_prev to 1, so the first left-phase fe after reset is a left boundary.
REQ-032 Reset mid-word SHALL drop the word in progress; after release, output SHALL restart at the next left boundary.

Verification
REQ-033 Reset release with hold empty, lrclk=0 at first fe -> frame_start and underrun pulse; underrun_cnt=1; dout=0 for the whole frame.
REQ-034 Transfer s_left=16'hA5C3, s_right=16'h8001 before a left boundary, 32-sclk frames -> dout bits after each boundary are 0, then A5C3 MSB-first, then 0 padding; right slot carries 8001; s_ready returns to 1 at the boundary.
REQ-035 s_valid held high, second pair 16'h1234/16'h5678 -> s_ready=0 until the next left boundary; the second frame carries 1234/5678.
REQ-036 s_valid rises in the exact Clk of the left boundary with hold empty -> underrun pulses; that pair plays in the following frame.
REQ-037 300 consecutive starved frames -> underrun_cnt=255 and holds.
REQ-038 Right slot of 10 sclk with SAMPLE_W=16 -> only 9 data bits are sent; the left boundary then loads correctly with no stuck state.
